// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads A/B buffers, streams skewed operands into an NxN systolic grid, captures its result
module systolic_ctrl #(
  parameter int N = 2,
  parameter int DW = 8,
  parameter int LAT = 1,
  localparam int AW = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              start,
  output logic              clear,
  output logic [N*DW-1:0]   a_row,
  output logic [N*DW-1:0]   b_col,
  input  logic [N*N*DW-1:0] c_flat,
  output logic [N*N*DW-1:0] result,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(3*N+LAT+1);
  typedef enum logic [1:0] {IDLE, CLR, FEED, DRAIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a_buf [N*N];
  logic [DW-1:0] b_buf [N*N];
  logic [N*DW-1:0] a_d, b_d;
  logic cap;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N*N; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else if (ld_en && state == IDLE && !busy && int'(ld_addr) < N*N) begin
      if (ld_sel) b_buf[ld_addr] <= ld_data;
      else a_buf[ld_addr] <= ld_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = start ? CLR : IDLE;
      CLR:   nxt = FEED;
      FEED:  nxt = (cnt == CW'(3*N-3)) ? DRAIN : FEED;
      DRAIN: nxt = (cnt == CW'(LAT-1)) ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < N; i++) begin
      a_d[i*DW +: DW] = (state == FEED && int'(cnt) >= i && int'(cnt) < i+N) ? a_buf[AW'(i*N + int'(cnt) - i)] : '0;
      b_d[i*DW +: DW] = (state == FEED && int'(cnt) >= i && int'(cnt) < i+N) ? b_buf[AW'((int'(cnt) - i)*N + i)] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clear <= 1'b0;
      busy <= 1'b0;
      a_row <= '0;
      b_col <= '0;
      cap <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      clear <= state == CLR;
      busy <= state != IDLE;
      a_row <= a_d;
      b_col <= b_d;
      cap <= state == DRAIN && cnt == CW'(LAT-1);
      done <= cap;
      if (cap) result <= c_flat;
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: drives systolic_ctrl against a 2x2 PE grid model and a matrix-product reference
module tb_systolic_ctrl;
  localparam int N = 2;
  localparam int DW = 8;
  localparam int LAT = 1;
  logic clk = 0;
  logic rst = 1;
  logic ld_en = 0;
  logic ld_sel = 0;
  logic [1:0] ld_addr = 0;
  logic [7:0] ld_data = 0;
  logic start = 0;
  logic clear, busy, done;
  logic [15:0] a_row, b_col;
  logic [31:0] c_flat, result;
  logic [7:0] ar [2][2];
  logic [7:0] br [2][2];
  logic [7:0] acc [2][2];
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;
  vec_t vecs [4];
  logic [15:0] ea [4];
  logic [15:0] eb [4];

  systolic_ctrl #(.N(N), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .clear(clear), .a_row(a_row), .b_col(b_col),
    .c_flat(c_flat), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ain(int i, int j);
    return j == 0 ? a_row[i*8 +: 8] : ar[i][j == 0 ? 0 : j-1];
  endfunction

  function automatic logic [7:0] bin(int i, int j);
    return i == 0 ? b_col[j*8 +: 8] : br[i == 0 ? 0 : i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        if (clear) begin
          acc[i][j] <= 8'd0;
          ar[i][j] <= 8'd0;
          br[i][j] <= 8'd0;
        end else begin
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
          ar[i][j] <= ain(i, j);
          br[i][j] <= bin(i, j);
        end
      end
  end

  always_comb begin
    c_flat = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        c_flat[(i*2+j)*8 +: 8] = acc[i][j];
  end

  function automatic logic [31:0] mm(logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += int'(a[(i*2+k)*8 +: 8]) * int'(b[(k*2+j)*8 +: 8]);
        r[(i*2+j)*8 +: 8] = 8'(s % 256);
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) begin
        ld_en = 1;
        ld_sel = s[0];
        ld_addr = k[1:0];
        ld_data = s == 1 ? b[k*8 +: 8] : a[k*8 +: 8];
        tick();
      end
    ld_en = 0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, n, lat);
  endtask

  task automatic run(input string nm, input logic [31:0] exp);
    start = 1;
    tick();
    start = 0;
    wait_done(nm, 7);
    chk({nm, " result"}, result, exp);
    chk({nm, " busy at done"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int nd;
    logic [31:0] ra, rb;
    vecs[0] = '{32'h04030201, 32'h08070605, 32'h322B1613};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202};
    vecs[2] = '{32'h01000001, 32'h0D0C0B0A, 32'h0D0C0B0A};
    vecs[3] = '{32'h00000000, 32'h11223344, 32'h00000000};
    ea = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
    eb = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset clear", {31'd0, clear}, 0);
    chk("reset a_row", {16'd0, a_row}, 0);
    chk("reset b_col", {16'd0, b_col}, 0);
    chk("reset result", result, 0);
    rst = 0;
    tick();
    load(vecs[0].a, vecs[0].b);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("basic clear", {31'd0, clear}, 1);
    chk("basic busy", {31'd0, busy}, 1);
    chk("basic clear a_row", {16'd0, a_row}, 0);
    for (int f = 0; f < 4; f++) begin
      tick();
      chk($sformatf("basic a_row f%0d", f), {16'd0, a_row}, {16'd0, ea[f]});
      chk($sformatf("basic b_col f%0d", f), {16'd0, b_col}, {16'd0, eb[f]});
      chk($sformatf("basic clear f%0d", f), {31'd0, clear}, 0);
    end
    tick();
    chk("basic drain a_row", {16'd0, a_row}, 0);
    chk("basic drain done", {31'd0, done}, 0);
    tick();
    chk("basic done edge7", {31'd0, done}, 1);
    chk("basic busy edge7", {31'd0, busy}, 0);
    chk("basic result", result, vecs[0].c);
    tick();
    chk("basic done pulse", {31'd0, done}, 0);
    chk("basic result hold", result, vecs[0].c);
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].a, vecs[v].b);
      run($sformatf("vec%0d", v), vecs[v].c);
    end
    load(vecs[0].a, vecs[0].b);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    start = 1;
    ld_en = 1;
    ld_sel = 0;
    ld_addr = 0;
    ld_data = 8'd99;
    tick();
    tick();
    start = 0;
    ld_en = 0;
    wait_done("busy_start", 3);
    chk("busy_start result", result, vecs[0].c);
    run("busy_rerun", vecs[0].c);
    ld_en = 1;
    ld_sel = 0;
    ld_addr = 0;
    ld_data = 8'd9;
    start = 1;
    tick();
    ld_en = 0;
    start = 0;
    wait_done("ld_start", 7);
    chk("ld_start result", result, mm(32'h04030209, vecs[0].b));
    load(vecs[0].a, vecs[0].b);
    start = 1;
    tick();
    wait_done("b2b first", 7);
    chk("b2b first busy", {31'd0, busy}, 0);
    chk("b2b first result", result, vecs[0].c);
    tick();
    start = 0;
    chk("b2b clear", {31'd0, clear}, 1);
    chk("b2b busy", {31'd0, busy}, 1);
    chk("b2b done low", {31'd0, done}, 0);
    wait_done("b2b second", 6);
    chk("b2b second result", result, vecs[0].c);
    for (int r = 0; r < 20; r++) begin
      ra = $urandom;
      rb = $urandom;
      load(ra, rb);
      run($sformatf("rand%0d", r), mm(ra, rb));
    end
    load(vecs[0].a, vecs[0].b);
    run("pre_reset", vecs[0].c);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    chk("midrst busy", {31'd0, busy}, 0);
    chk("midrst done", {31'd0, done}, 0);
    chk("midrst clear", {31'd0, clear}, 0);
    chk("midrst a_row", {16'd0, a_row}, 0);
    chk("midrst b_col", {16'd0, b_col}, 0);
    chk("midrst result", result, 0);
    tick();
    rst = 0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) nd++;
    end
    chk("midrst no done", nd, 0);
    chk("midrst idle busy", {31'd0, busy}, 0);
    run("after_reset", 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for an N x N systolic grid of PE MAC cells. It holds operand matrices A and B in internal buffers loaded over a simple write port. On start it pulses clear to the grid, streams skewed rows of A into the left edge and skewed columns of B into the top edge, then waits out the drain latency. It finally latches the grid's c_out values into a result register and pulses done.

Parameters:
N, 2, grid dimension (rows = columns)
DW, 8, operand/result element width
LAT, 1, drain cycles between last feed cycle and result capture
AW, $clog2(N*N), load address width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_en  in  1  write strobe for operand buffers
ld_sel  in  1  0 = write A buffer, 1 = write B buffer
ld_addr  in  AW  element index i*N+j
ld_data  in  DW  element value
start  in  1  begin one matrix multiply
clear  out  1  to all PEs; zeroes accumulators
a_row  out  N*DW  left-edge inputs; row i at [i*DW +: DW]
b_col  out  N*DW  top-edge inputs; column j at [j*DW +: DW]
c_flat  in  N*N*DW  PE c_out values; PE(i,j) at [(i*N+j)*DW +: DW]
result  out  N*N*DW  captured C matrix, same packing as c_flat
busy  out  1  high in CLEAR/FEED/DRAIN
done  out  1  one-cycle pulse after capture

Behaviour:
- All outputs registered. Reset values: state IDLE, clear=0, a_row=0, b_col=0, result=0, busy=0, done=0. A and B buffers zeroed; counters zeroed.
- Reset asserted mid-operation: next cycle is IDLE with all reset values; no done pulse.
- Load: when ld_en=1 and state IDLE, write buffer[ld_sel][ld_addr]=ld_data at the clock edge. Ignored while busy. ld_addr >= N*N is ignored.
- FSM transitions:
  - IDLE -> CLEAR when start=1. start is ignored in every other state.
  - CLEAR: 1 cycle; clear=1, a_row=b_col=0.
  - FEED: 3N-2 cycles, counter f = 0..3N-3.
    - a_row[i] = A[i][f-i] if 0 <= f-i < N, else 0.
    - b_col[j] = B[f-j][j] if 0 <= f-j < N, else 0.
    - clear=0.
  - DRAIN: LAT cycles; a_row=b_col=0.
  - At the edge ending the last DRAIN cycle: result <= c_flat; done=1 for the following cycle; state -> IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge 3N+LAT (N=2, LAT=1: edge 7).
- busy=1 exactly while in CLEAR, FEED or DRAIN; it falls on the same edge done rises.
- start high during the done cycle is accepted, so back-to-back runs lose no cycle.
- result holds its value until the next capture or reset.
- Buffers persist across runs, so a rerun without reload reproduces the same stream.
- Arithmetic: the controller performs none. c_flat is captured verbatim; accumulator wrap is the PE's modulo-2^DW behaviour.
- Simultaneous ld_en and start in IDLE: the write takes effect and the run uses the new value. The buffer is read starting the FEED cycle after.

Test Plan:
- Reset: drive rst 2 cycles mid-FEED -> next cycle busy=0, done=0, clear=0, a_row=b_col=0, result=0; no later done.
- Basic 2x2 (N=2, grid of 4 PEs on bench): load A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start -> clear=1 one cycle, then a_row sequence {(1,0),(2,3),(0,4),(0,0)} and b_col sequence {(5,0),(7,6),(0,8),(0,0)}, done at edge 7, result=[[19,22],[43,50]].
- Wrap: A=B=all 255 -> each element = 2*(255*255) mod 256 = 2, result all 0x02.
- Start/load while busy: assert start and ld_en with new data during FEED -> no restart, buffers unchanged, result as in the basic case.
- Back-to-back: hold start high through the done cycle -> the second run begins immediately with clear the cycle after done and an identical result; busy low only during the done cycle.
- Rerun without reload after reset: result=0 (buffers cleared by reset), done asserted normally.
